z80_io_timer_responder: RTL
===========================

Name: z80_io_timer_responder

Overview:
I/O-mapped peripheral on the external Z80 bus, on the far side of the CPU pad ring. Decodes I/O read/write cycles to a 4-port window and drives the shared data bus on reads. Contains a prescaled 8-bit reload timer that raises /INT. Answers the interrupt-acknowledge cycle (/M1 + /IORQ) with a programmable vector.

Parameters:
PORT_BASE, 8'h40, I/O window base; bits 1:0 must be 0; window = PORT_BASE..PORT_BASE+3
PRESCALE, 16, clk cycles per timer tick; must be >= 1
VECTOR_RST, 8'hFF, reset value of VECTOR register

Ports:
clk  input  1  bus clock, same clock as CPU
n_reset  input  1  asynchronous active-low reset
addr  input  16  CPU address bus; only addr[7:0] decoded
n_iorq  input  1  CPU /IORQ
n_m1  input  1  CPU /M1
n_mreq  input  1  CPU /MREQ; memory cycles ignored
n_rd  input  1  CPU /RD
n_wr  input  1  CPU /WR
bus_data_in  input  8  data driven by CPU on writes
bus_data_out  output  8  data this block drives on reads/INTA
bus_data_oe  output  1  high = block drives data bus
n_int  output  1  active-low interrupt request to CPU

Behaviour:
- One clock domain, clk rising edge. Asynchronous active-low reset n_reset. All bus inputs are sampled on clk.
- Register map (offset = addr[1:0]; hit = addr[7:2]==PORT_BASE[7:2]):
  - 0 CTRL: bit0 TEN (timer enable), bit1 IEN (interrupt enable); bits 7:2 read 0.
  - 1 RELOAD: R/W.
  - 2 VECTOR: R/W.
  - 3 STATUS: read bit0 PEND, bit1 OVR, rest 0; write-1-to-clear per bit.
- Reset values: CTRL=0, RELOAD=0, VECTOR=VECTOR_RST, PEND=0, OVR=0, counter=0, prescaler=0, state IDLE, bus_data_out=0, bus_data_oe=0, n_int=1. Asserting reset mid-cycle releases the bus immediately.
- FSM states: IDLE, IORD, IOWR, INTA, WAIT_END.
  - IDLE -> IORD: n_iorq=0, n_rd=0, n_m1=1, hit. Next edge: bus_data_out=register value, bus_data_oe=1 (1-cycle latency; fits inside the Z80 automatic I/O wait state).
  - IORD -> IDLE: on the first edge with n_rd=1 or n_iorq=1; bus_data_oe=0 on that same edge.
  - IDLE -> IOWR: n_iorq=0, n_wr=0, n_m1=1, hit. Register written exactly once, on the entering edge, with bus_data_in. Stays in IOWR until n_wr=1 or n_iorq=1, then IDLE. A long strobe never rewrites.
  - IDLE -> INTA: n_m1=0 and n_iorq=0, with PEND=1 and IEN=1. Next edge: bus_data_out=VECTOR, bus_data_oe=1. On the edge n_iorq returns 1: oe=0, PEND cleared, -> IDLE.
  - IDLE -> WAIT_END: n_m1=0 and n_iorq=0 while not (PEND and IEN). Bus is never driven; this is another device's acknowledge. Return to IDLE when n_iorq=1.
  - Non-hit I/O cycles and all n_mreq cycles leave state IDLE; outputs unchanged.
- Timer:
  - When TEN=1, the prescaler counts PRESCALE-1 down to 0. A tick occurs on 0, then the prescaler reloads.
  - On a tick: if counter==0, expire and load counter=RELOAD; else counter-1. Expiry period is (RELOAD+1)*PRESCALE clocks.
  - When TEN=0, prescaler and counter hold.
  - Writing RELOAD also loads counter=value and prescaler=PRESCALE-1.
- Expiry sets PEND. If PEND was already 1, it also sets OVR.
- n_int is registered: n_int = ~(PEND & IEN), one cycle after the change.
- Simultaneous events: a set (expiry) beats any clear (INTA end or STATUS write-1) in the same cycle. A CTRL write takes effect on the next edge.

Test Plan:
1. Reset, then OUT (0x41),0x05 and IN (0x41) -> bus_data_oe rises one cycle after /RD&/IORQ low; bus_data_out=0x05; oe falls on the edge /RD rises.
2. PRESCALE=16, RELOAD=3, CTRL=0x03 -> first expiry 64 clocks after TEN is set; PEND=1; n_int=0 one cycle later; STATUS reads 0x01.
3. Pending interrupt, then INTA cycle (/M1=0, /IORQ=0) with VECTOR=0x38 -> bus drives 0x38; PEND=0 and n_int=1 after /IORQ rises.
4. Two expiries with no service -> STATUS=0x03. OUT (0x43),0x02 -> STATUS=0x01, n_int stays 0.
5. Expiry in the same cycle as an STATUS write-1 to bit0 -> PEND remains 1. INTA with IEN=0 -> oe stays 0 throughout.
6. Port 0x44 read, a memory read at 0x0041, and a /WR held for 5 cycles to 0x42 -> no drive for 0x44 or the memory read; VECTOR written once. n_reset pulsed during IORD -> bus_data_oe=0 asynchronously.

Source files
------------

// File: rtl/z80_io_timer_responder.sv
// Z80 I/O-mapped timer peripheral: 4-port register window, prescaled reload
// timer raising /INT, and an interrupt-acknowledge responder with a vector.
module z80_io_timer_responder #(
    parameter logic [7:0]  PORT_BASE  = 8'h40,
    parameter int unsigned PRESCALE   = 16,
    parameter logic [7:0]  VECTOR_RST = 8'hFF
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] addr,
    input  logic        n_iorq,
    input  logic        n_m1,
    input  logic        n_mreq,
    input  logic        n_rd,
    input  logic        n_wr,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    output logic        n_int
);

    // state    | meaning
    // IDLE     | no cycle in progress
    // IORD     | I/O read of the window, bus driven with register data
    // IOWR     | I/O write, register already written, waiting for strobe end
    // INTA     | our acknowledge, bus driven with VECTOR
    // WAIT_END | someone else's acknowledge, wait for /IORQ to rise
    typedef enum logic [2:0] {
        S_IDLE,
        S_IORD,
        S_IOWR,
        S_INTA,
        S_WAIT_END
    } state_t;

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    state_t state, state_nxt;

    logic          ctrl_ten, ctrl_ien;
    logic [7:0]    reload_reg, vector_reg, count;
    logic [PW-1:0] presc;
    logic          pend, ovr;

    logic       hit, io_rd_req, io_wr_req, inta_req, irq_active;
    logic       wr_en, wr_ctrl, wr_reload, wr_vector, wr_status;
    logic       tick, expire, inta_done, pend_clr, ovr_clr;
    logic [7:0] rd_data;
    logic       oe_nxt;
    logic [7:0] dout_nxt;
    logic       unused_addr;

    assign unused_addr = ^addr[15:8];

    assign hit        = (addr[7:2] == PORT_BASE[7:2]);
    assign io_rd_req  = !n_iorq && !n_rd && n_m1 && n_mreq && hit;
    assign io_wr_req  = !n_iorq && !n_wr && n_m1 && n_mreq && hit;
    assign inta_req   = !n_m1 && !n_iorq;
    assign irq_active = pend && ctrl_ien;

    // Registers are written only on the edge that enters IOWR.
    assign wr_en     = (state == S_IDLE) && io_wr_req;
    assign wr_ctrl   = wr_en && (addr[1:0] == 2'd0);
    assign wr_reload = wr_en && (addr[1:0] == 2'd1);
    assign wr_vector = wr_en && (addr[1:0] == 2'd2);
    assign wr_status = wr_en && (addr[1:0] == 2'd3);

    always_comb begin
        rd_data = 8'h00;
        case (addr[1:0])
            2'd0: rd_data = {6'b0, ctrl_ien, ctrl_ten};
            2'd1: rd_data = reload_reg;
            2'd2: rd_data = vector_reg;
            default: rd_data = {6'b0, ovr, pend};
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (inta_req) begin
                    state_nxt = irq_active ? S_INTA : S_WAIT_END;
                end else if (io_rd_req) begin
                    state_nxt = S_IORD;
                end else if (io_wr_req) begin
                    state_nxt = S_IOWR;
                end
            end
            S_IORD:     if (n_rd || n_iorq) state_nxt = S_IDLE;
            S_IOWR:     if (n_wr || n_iorq) state_nxt = S_IDLE;
            S_INTA:     if (n_iorq) state_nxt = S_IDLE;
            S_WAIT_END: if (n_iorq) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs (data holds its last value while the bus is released)
    always_comb begin
        oe_nxt   = 1'b0;
        dout_nxt = bus_data_out;
        case (state_nxt)
            S_IORD: begin
                oe_nxt   = 1'b1;
                dout_nxt = rd_data;
            end
            S_INTA: begin
                oe_nxt   = 1'b1;
                dout_nxt = vector_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bus_data_oe  <= 1'b0;
            bus_data_out <= 8'h00;
            n_int        <= 1'b1;
        end else begin
            bus_data_oe  <= oe_nxt;
            bus_data_out <= dout_nxt;
            n_int        <= !irq_active;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ctrl_ten   <= 1'b0;
            ctrl_ien   <= 1'b0;
            reload_reg <= 8'h00;
            vector_reg <= VECTOR_RST;
        end else begin
            if (wr_ctrl) begin
                ctrl_ten <= bus_data_in[0];
                ctrl_ien <= bus_data_in[1];
            end
            if (wr_reload) reload_reg <= bus_data_in;
            if (wr_vector) vector_reg <= bus_data_in;
        end
    end

    assign tick   = ctrl_ten && (presc == '0);
    assign expire = tick && (count == 8'h00) && !wr_reload;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            presc <= '0;
            count <= 8'h00;
        end else if (wr_reload) begin
            presc <= PRESC_MAX;
            count <= bus_data_in;
        end else if (ctrl_ten) begin
            presc <= tick ? PRESC_MAX : presc - 1'b1;
            if (tick) begin
                count <= (count == 8'h00) ? reload_reg : count - 8'd1;
            end
        end
    end

    assign inta_done = (state == S_INTA) && n_iorq;
    assign pend_clr  = inta_done || (wr_status && bus_data_in[0]);
    assign ovr_clr   = wr_status && bus_data_in[1];

    // An expiry always wins over a clear landing on the same edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pend <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (expire)        pend <= 1'b1;
            else if (pend_clr) pend <= 1'b0;
            if (expire && pend) ovr <= 1'b1;
            else if (ovr_clr)   ovr <= 1'b0;
        end
    end

endmodule
